reg_file_scb: RTL and testbench
===============================

Name: reg_file_scb

Overview:
- Parametrised successor of the team's 4-bit, 16-entry register file.
- Adds configurable data width and depth, two write ports with defined collision priority, and same-cycle write-to-read forwarding.
- Register 0 is hardwired to zero.
- Each entry carries a busy (scoreboard) bit so the decode stage can detect pending producers.
- Sits between decode (read and issue) and writeback (write ports) in the RISC-V core.

Parameters:
- DATA_W, 32, data width of each register.
- ADDR_W, 5, register select width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1 entry 0 reads as 0, ignores writes and is never busy; when 0 entry 0 is an ordinary register.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- read_reg_num1  in  ADDR_W  read port 1 select.
- read_reg_num2  in  ADDR_W  read port 2 select.
- read_data1  out  DATA_W  read port 1 data.
- read_data2  out  DATA_W  read port 2 data.
- read_ready1  out  1  port 1 operand valid (not pending).
- read_ready2  out  1  port 2 operand valid.
- regwrite_a  in  1  write port A enable.
- write_reg_a  in  ADDR_W  write port A select.
- write_data_a  in  DATA_W  write port A data.
- regwrite_b  in  1  write port B enable (higher priority).
- write_reg_b  in  ADDR_W  write port B select.
- write_data_b  in  DATA_W  write port B data.
- issue_valid  in  1  mark a destination register pending.
- issue_reg  in  ADDR_W  destination being issued.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset (asynchronous, active-high): all DEPTH registers cleared to 0 and all busy bits cleared. While reset is held, read_data1/2 = 0, read_ready1/2 = 1 and busy_any = 0. Reset asserted mid-operation discards pending writes and issues immediately.
- Reads are combinational, with zero-latency forwarding. Priority for read_dataN at address r:
  1. r==0 with ZERO_REG=1 gives 0.
  2. Else if regwrite_b and write_reg_b==r, give write_data_b.
  3. Else if regwrite_a and write_reg_a==r, give write_data_a.
  4. Else give the stored value.
- read_readyN at address r:
  - 1 if r==0 with ZERO_REG=1.
  - Else 1 if busy[r]==0.
  - Else 1 if a write to r is enabled this cycle.
  - Else 0.
  - issue_valid in the same cycle does not affect read_ready (the issue takes effect next cycle).
- Writes on posedge clock:
  - Port A writes when regwrite_a is high; port B writes when regwrite_b is high.
  - Writes to entry 0 with ZERO_REG=1 are dropped.
  - Both ports writing the same address: port B's data is stored.
- Busy bits on posedge clock:
  - A write to r clears busy[r].
  - issue_valid sets busy[issue_reg].
  - If issue and write target the same r in the same cycle, set wins (a new producer supersedes the old one).
  - Issue to entry 0 with ZERO_REG=1 is ignored.
  - Writing a non-busy register is legal; busy stays 0.
- busy_any is combinational from the busy bits, with no forwarding.
- All address widths are exact (DEPTH = 2**ADDR_W), so there is no out-of-range case.
- Data is stored unmodified at DATA_W bits; there is no extension or truncation.

Decomposition:
- Shared package/include file holds DATA_W, ADDR_W and ZERO_REG defaults and a localparam DEPTH = 1<<ADDR_W.
- One natural sub-module, rf_fwd_port: the combinational forwarding mux plus ready logic for one read port. Instantiate it twice.
- Storage, busy vector and write/issue sequencing stay in the top module.

Test Plan:
1. Reset, then with reset high read regs 5 and 31 -> data 0, ready 1, busy_any 0. Release at 10 ns.
2. regwrite_a with write_reg_a=1, write_data_a=0xA; same cycle read_reg_num1=1 -> read_data1=0xA (forwarded) before the edge, and still 0xA after the edge with regwrite_a low.
3. Both ports write reg 3 (A=0xC, B=0xD) -> combinational read of 3 gives 0xD; stored value is 0xD next cycle.
4. Write reg 0 with 0xFFFF_FFFF, issue reg 0 (ZERO_REG=1) -> read 0 gives 0, ready 1, busy_any stays 0.
5. Issue reg 7:
   - next cycle read_ready1=0 and busy_any=1;
   - then regwrite_a to reg 7 with 0x55 -> same cycle read_ready1=1 and read_data1=0x55;
   - next cycle busy[7]=0 and busy_any=0.
6. Issue reg 9 and write reg 9 in the same cycle -> next cycle busy remains set, read_ready=0, stored data = written value. Then assert reset mid-pending -> busy_any=0 and reg 9 reads 0 immediately.

Source files
------------

// File: rtl/reg_file_scb_pkg.sv
// Shared defaults for the scoreboarded register file: widths, zero-register mode, depth.
// Combinational reads; writes and scoreboard updates take effect at the next clock edge.
package reg_file_scb_pkg;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam bit          ZERO_REG_DEF = 1'b1;
  localparam int unsigned DEPTH        = 1 << ADDR_W_DEF;
endpackage

// File: rtl/reg_file_scb_fwd_port.sv
// One read port: forwarding mux (B over A over storage) and operand-ready logic.
// Purely combinational; no backpressure, a not-ready operand is reported on rd_ready_o.
module rf_fwd_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] stored_data_i,
  input  logic              stored_busy_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_a_i,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] wb_i,
  input  logic [DATA_W-1:0] wd_b_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_ready_o
);
  logic hit_zero, hit_a, hit_b;

  always_comb begin
    hit_zero = ZERO_REG && (rd_addr_i == '0);
    hit_a    = we_a_i && (wa_i == rd_addr_i);
    hit_b    = we_b_i && (wb_i == rd_addr_i);

    rd_data_o = stored_data_i;
    if (hit_zero)   rd_data_o = '0;
    else if (hit_b) rd_data_o = wd_b_i;
    else if (hit_a) rd_data_o = wd_a_i;

    // An in-flight write resolves a pending operand in the same cycle.
    rd_ready_o = hit_zero || !stored_busy_i || hit_a || hit_b;
  end
endmodule

// File: rtl/reg_file_scb.sv
// Two-write/two-read register file with per-entry busy scoreboard and same-cycle forwarding.
// Reads combinational; writes/issues land on the next posedge; no backpressure (ready flags only).
module reg_file_scb
  import reg_file_scb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = ZERO_REG_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_reg_num1,
  input  logic [ADDR_W-1:0] read_reg_num2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              read_ready1,
  output logic              read_ready2,
  input  logic              regwrite_a,
  input  logic [ADDR_W-1:0] write_reg_a,
  input  logic [DATA_W-1:0] write_data_a,
  input  logic              regwrite_b,
  input  logic [ADDR_W-1:0] write_reg_b,
  input  logic [DATA_W-1:0] write_data_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              busy_any
);
  localparam int unsigned NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic              we_a, we_b, iss;

  // Masking with reset keeps outputs at their cleared values while reset is held.
  assign we_a = regwrite_a && !reset && !(ZERO_REG && write_reg_a == '0);
  assign we_b = regwrite_b && !reset && !(ZERO_REG && write_reg_b == '0);
  assign iss  = issue_valid && !reset && !(ZERO_REG && issue_reg == '0);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (we_a) begin
      regs_d[write_reg_a] = write_data_a;
      busy_d[write_reg_a] = 1'b0;
    end
    if (we_b) begin
      regs_d[write_reg_b] = write_data_b;
      busy_d[write_reg_b] = 1'b0;
    end
    // A new producer supersedes a completing one.
    if (iss) busy_d[issue_reg] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_any = |busy_q;

  rf_fwd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_port1 (
    .rd_addr_i     (read_reg_num1),
    .stored_data_i (regs_q[read_reg_num1]),
    .stored_busy_i (busy_q[read_reg_num1]),
    .we_a_i        (we_a),
    .wa_i          (write_reg_a),
    .wd_a_i        (write_data_a),
    .we_b_i        (we_b),
    .wb_i          (write_reg_b),
    .wd_b_i        (write_data_b),
    .rd_data_o     (read_data1),
    .rd_ready_o    (read_ready1)
  );

  rf_fwd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_port2 (
    .rd_addr_i     (read_reg_num2),
    .stored_data_i (regs_q[read_reg_num2]),
    .stored_busy_i (busy_q[read_reg_num2]),
    .we_a_i        (we_a),
    .wa_i          (write_reg_a),
    .wd_a_i        (write_data_a),
    .we_b_i        (we_b),
    .wb_i          (write_reg_b),
    .wd_b_i        (write_data_b),
    .rd_data_o     (read_data2),
    .rd_ready_o    (read_ready2)
  );
endmodule

// File: tb/tb_reg_file_scb.sv
// Directed bench for reg_file_scb: expected values queued at drive time, popped at sample time.
module tb_reg_file_scb;
  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  read_reg_num1, read_reg_num2;
  logic [31:0] read_data1, read_data2;
  logic        read_ready1, read_ready2;
  logic        regwrite_a, regwrite_b, issue_valid;
  logic [4:0]  write_reg_a, write_reg_b, issue_reg;
  logic [31:0] write_data_a, write_data_b;
  logic        busy_any;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  always #5 clock = ~clock;

  reg_file_scb dut (
    .clock(clock), .reset(reset),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .read_data1(read_data1), .read_data2(read_data2),
    .read_ready1(read_ready1), .read_ready2(read_ready2),
    .regwrite_a(regwrite_a), .write_reg_a(write_reg_a), .write_data_a(write_data_a),
    .regwrite_b(regwrite_b), .write_reg_b(write_reg_b), .write_data_b(write_data_b),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .busy_any(busy_any)
  );

  task automatic expect_v(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    regwrite_a = 1'b0; regwrite_b = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    write_reg_a = 5'd0; write_reg_b = 5'd0; issue_reg = 5'd0;
    write_data_a = '0; write_data_b = '0;

    // 1: reset state
    read_reg_num1 = 5'd5; read_reg_num2 = 5'd31;
    expect_v("rst_data1", 32'h0);
    expect_v("rst_data2", 32'h0);
    expect_v("rst_ready1", 32'h1);
    expect_v("rst_ready2", 32'h1);
    expect_v("rst_busy_any", 32'h0);
    #2;
    check(read_data1); check(read_data2);
    check({31'b0, read_ready1}); check({31'b0, read_ready2});
    check({31'b0, busy_any});
    #8 reset = 1'b0;   // t = 10 ns, a negedge

    // 2: forwarding from port A, then stored value
    regwrite_a = 1'b1; write_reg_a = 5'd1; write_data_a = 32'hA; read_reg_num1 = 5'd1;
    expect_v("fwd_a_data", 32'hA);
    #1 check(read_data1);
    @(negedge clock); idle();
    expect_v("stored_a_data", 32'hA);
    #1 check(read_data1);

    // 3: both ports hit the same register, B wins
    @(negedge clock);
    regwrite_a = 1'b1; write_reg_a = 5'd3; write_data_a = 32'hC;
    regwrite_b = 1'b1; write_reg_b = 5'd3; write_data_b = 32'hD;
    read_reg_num1 = 5'd3;
    expect_v("collide_fwd", 32'hD);
    #1 check(read_data1);
    @(negedge clock); idle();
    expect_v("collide_stored", 32'hD);
    #1 check(read_data1);

    // 4: register 0 ignores writes and issues
    @(negedge clock);
    regwrite_a = 1'b1; write_reg_a = 5'd0; write_data_a = 32'hFFFF_FFFF;
    issue_valid = 1'b1; issue_reg = 5'd0; read_reg_num1 = 5'd0;
    expect_v("zero_fwd_data", 32'h0);
    expect_v("zero_fwd_ready", 32'h1);
    #1 check(read_data1); check({31'b0, read_ready1});
    @(negedge clock); idle();
    expect_v("zero_data", 32'h0);
    expect_v("zero_ready", 32'h1);
    expect_v("zero_busy_any", 32'h0);
    #1 check(read_data1); check({31'b0, read_ready1}); check({31'b0, busy_any});

    // 5: issue, pending, resolve by write
    @(negedge clock);
    issue_valid = 1'b1; issue_reg = 5'd7; read_reg_num1 = 5'd7;
    expect_v("issue_same_cycle_ready", 32'h1);
    #1 check({31'b0, read_ready1});
    @(negedge clock); idle();
    expect_v("pending_ready", 32'h0);
    expect_v("pending_busy_any", 32'h1);
    #1 check({31'b0, read_ready1}); check({31'b0, busy_any});
    @(negedge clock);
    regwrite_a = 1'b1; write_reg_a = 5'd7; write_data_a = 32'h55;
    expect_v("resolve_ready", 32'h1);
    expect_v("resolve_data", 32'h55);
    expect_v("resolve_busy_any_nofwd", 32'h1);
    #1 check({31'b0, read_ready1}); check(read_data1); check({31'b0, busy_any});
    @(negedge clock); idle();
    expect_v("resolved_busy_any", 32'h0);
    expect_v("resolved_ready", 32'h1);
    expect_v("resolved_data", 32'h55);
    #1 check({31'b0, busy_any}); check({31'b0, read_ready1}); check(read_data1);

    // 6: issue and write to the same register, set wins; then reset mid-pending
    @(negedge clock);
    issue_valid = 1'b1; issue_reg = 5'd9;
    regwrite_b = 1'b1; write_reg_b = 5'd9; write_data_b = 32'h1234_5678;
    read_reg_num2 = 5'd9;
    @(negedge clock); idle();
    expect_v("iss_wr_ready2", 32'h0);
    expect_v("iss_wr_busy_any", 32'h1);
    expect_v("iss_wr_data2", 32'h1234_5678);
    #1 check({31'b0, read_ready2}); check({31'b0, busy_any}); check(read_data2);
    #1 reset = 1'b1;
    expect_v("midrst_busy_any", 32'h0);
    expect_v("midrst_data2", 32'h0);
    expect_v("midrst_ready2", 32'h1);
    #1 check({31'b0, busy_any}); check(read_data2); check({31'b0, read_ready2});
    @(negedge clock); reset = 1'b0;
    expect_v("postrst_data1", 32'h0);
    read_reg_num1 = 5'd3;
    #1 check(read_data1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
